// File: rtl/char_console_writer_pkg.sv
// char_console_writer_pkg: text console geometry, control codes and writer FSM states
package char_console_writer_pkg;
    localparam int CHARS_HORZ = 80;
    localparam int CHARS_VERT = 30;
    localparam int ASCII_SIZE = 8;
    localparam int ROW_W = $clog2(CHARS_VERT);
    localparam int COL_W = $clog2(CHARS_HORZ);
    localparam logic [ASCII_SIZE-1:0] CH_BS = 8'h08;
    localparam logic [ASCII_SIZE-1:0] CH_TAB = 8'h09;
    localparam logic [ASCII_SIZE-1:0] CH_LF = 8'h0A;
    localparam logic [ASCII_SIZE-1:0] CH_FF = 8'h0C;
    localparam logic [ASCII_SIZE-1:0] CH_CR = 8'h0D;
    localparam logic [ASCII_SIZE-1:0] CH_SPACE = 8'h20;
    localparam logic [ASCII_SIZE-1:0] CH_TILDE = 8'h7E;
    typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} writerState_t;
endpackage

// File: rtl/char_console_writer_cursor.sv
// console_cursor_next: decodes one accepted byte into the cursor move, an optional cell write
// and a request to start scrolling or clearing the screen.
module console_cursor_next
    import char_console_writer_pkg::*;
(
    input  logic [ROW_W-1:0]      row,
    input  logic [COL_W-1:0]      col,
    input  logic [ASCII_SIZE-1:0] inChar,
    output logic [ROW_W-1:0]      nextRow,
    output logic [COL_W-1:0]      nextCol,
    output logic                  writeEn,
    output logic [ROW_W-1:0]      writeRow,
    output logic [COL_W-1:0]      writeCol,
    output logic [ASCII_SIZE-1:0] writeData,
    output logic                  startScroll,
    output logic                  startClear
);
    logic printable, lastRow, lastCol, newLine;
    logic [COL_W:0] tabCol;
    assign printable = inChar >= CH_SPACE && inChar <= CH_TILDE;
    assign lastRow = row == ROW_W'(CHARS_VERT - 1);
    assign lastCol = col == COL_W'(CHARS_HORZ - 1);
    assign tabCol = {1'b0, col | COL_W'(7)} + (COL_W + 1)'(1);
    always_comb begin
        nextRow = row;
        nextCol = col;
        writeEn = 1'b0;
        writeRow = row;
        writeCol = col;
        writeData = inChar;
        startScroll = 1'b0;
        startClear = 1'b0;
        newLine = 1'b0;
        if (printable) begin
            writeEn = 1'b1;
            newLine = lastCol;
            nextCol = col + COL_W'(1);
        end else if (inChar == CH_LF) begin
            newLine = 1'b1;
        end else if (inChar == CH_CR) begin
            nextCol = '0;
        end else if (inChar == CH_TAB) begin
            newLine = tabCol >= (COL_W + 1)'(CHARS_HORZ);
            nextCol = tabCol[COL_W-1:0];
        end else if (inChar == CH_BS) begin
            // Backspace erases the cell it lands on, wrapping to the end of the previous row
            if (col != '0) begin
                nextCol = col - COL_W'(1);
                writeEn = 1'b1;
            end else if (row != '0) begin
                nextRow = row - ROW_W'(1);
                nextCol = COL_W'(CHARS_HORZ - 1);
                writeEn = 1'b1;
            end
            writeRow = nextRow;
            writeCol = nextCol;
            writeData = CH_SPACE;
        end else if (inChar == CH_FF) begin
            nextRow = '0;
            nextCol = '0;
            startClear = 1'b1;
        end
        if (newLine) begin
            nextCol = '0;
            nextRow = lastRow ? row : row + ROW_W'(1);
            startScroll = lastRow;
        end
    end
endmodule

// File: rtl/char_console_writer.sv
// char_console_writer: owns the character cell buffer and cursor, accepts bytes over valid/ready,
// and scrolls or clears one row per cycle while busy.
module char_console_writer
    import char_console_writer_pkg::*;
(
    input  logic                  clk_25M,
    input  logic                  reset,
    input  logic [ASCII_SIZE-1:0] charIn,
    input  logic                  charValid,
    output logic                  charReady,
    output logic                  busy,
    output logic [ROW_W-1:0]      cursorRow,
    output logic [COL_W-1:0]      cursorCol,
    output logic [CHARS_VERT-1:0][CHARS_HORZ-1:0][ASCII_SIZE-1:0] charBuffer
);
    localparam logic [CHARS_HORZ-1:0][ASCII_SIZE-1:0] BLANK_ROW = {CHARS_HORZ{CH_SPACE}};
    writerState_t state, nextState;
    logic [ROW_W-1:0] rowIdx, nextRow, writeRow;
    logic [COL_W-1:0] nextCol, writeCol;
    logic [ASCII_SIZE-1:0] writeData;
    logic accept, lastIdx, writeEn, startScroll, startClear;
    assign charReady = state == IDLE;
    assign busy = !charReady;
    assign accept = charValid && charReady;
    assign lastIdx = rowIdx == ROW_W'(CHARS_VERT - 1);
    console_cursor_next cursorNext (
        .row(cursorRow),
        .col(cursorCol),
        .inChar(charIn),
        .nextRow(nextRow),
        .nextCol(nextCol),
        .writeEn(writeEn),
        .writeRow(writeRow),
        .writeCol(writeCol),
        .writeData(writeData),
        .startScroll(startScroll),
        .startClear(startClear)
    );
    always_ff @(posedge clk_25M or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end
    always_comb begin
        nextState = state;
        if (state == IDLE && accept) nextState = startScroll ? SCROLL : startClear ? CLEAR : IDLE;
        else if (state != IDLE && lastIdx) nextState = IDLE;
    end
    // rowIdx idles at zero so each scroll/clear starts from the top row
    always_ff @(posedge clk_25M or posedge reset) begin
        if (reset) begin
            charBuffer <= {CHARS_VERT{BLANK_ROW}};
            cursorRow <= '0;
            cursorCol <= '0;
            rowIdx <= '0;
        end else begin
            rowIdx <= state == IDLE ? '0 : rowIdx + ROW_W'(1);
            if (accept) begin
                cursorRow <= nextRow;
                cursorCol <= nextCol;
                if (writeEn) charBuffer[writeRow][writeCol] <= writeData;
            end
            if (state == SCROLL) charBuffer[rowIdx] <= lastIdx ? BLANK_ROW : charBuffer[rowIdx + ROW_W'(1)];
            if (state == CLEAR) charBuffer[rowIdx] <= BLANK_ROW;
        end
    end
endmodule

// File: tb/tb_char_console_writer.sv
// tb_char_console_writer: directed byte streams checked every cycle against a whole-screen model.
module tb_char_console_writer;
    import char_console_writer_pkg::*;
    logic clk = 1'b0, reset = 1'b1, charValid = 1'b0;
    logic [7:0] charIn = 8'h00;
    logic charReady, busy;
    logic [ROW_W-1:0] cursorRow;
    logic [COL_W-1:0] cursorCol;
    logic [CHARS_VERT-1:0][CHARS_HORZ-1:0][ASCII_SIZE-1:0] charBuffer;
    int checks = 0, errors = 0;
    logic [7:0] mdl [30][80];
    int mRow, mCol, busyLeft;

    char_console_writer dut (
        .clk_25M(clk),
        .reset(reset),
        .charIn(charIn),
        .charValid(charValid),
        .charReady(charReady),
        .busy(busy),
        .cursorRow(cursorRow),
        .cursorCol(cursorCol),
        .charBuffer(charBuffer)
    );

    always #5 clk = ~clk;

    function automatic void mdlClearAll();
        for (int r = 0; r < 30; r++) for (int c = 0; c < 80; c++) mdl[r][c] = 8'h20;
    endfunction

    function automatic void mdlNewLine();
        mCol = 0;
        if (mRow < 29) mRow++;
        else begin
            for (int r = 0; r < 29; r++) for (int c = 0; c < 80; c++) mdl[r][c] = mdl[r+1][c];
            for (int c = 0; c < 80; c++) mdl[29][c] = 8'h20;
            busyLeft = 30;
        end
    endfunction

    function automatic void mdlApply(input logic [7:0] b);
        int t;
        if (b >= 8'h20 && b <= 8'h7E) begin
            mdl[mRow][mCol] = b;
            if (mCol == 79) mdlNewLine();
            else mCol++;
        end else if (b == 8'h0A) mdlNewLine();
        else if (b == 8'h0D) mCol = 0;
        else if (b == 8'h09) begin
            t = (mCol | 7) + 1;
            if (t >= 80) mdlNewLine();
            else mCol = t;
        end else if (b == 8'h08) begin
            if (mCol > 0) begin
                mCol--;
                mdl[mRow][mCol] = 8'h20;
            end else if (mRow > 0) begin
                mRow--;
                mCol = 79;
                mdl[mRow][mCol] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            mRow = 0;
            mCol = 0;
            mdlClearAll();
            busyLeft = 30;
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdlClearAll();
            mRow = 0;
            mCol = 0;
            busyLeft = 0;
        end else if (busyLeft > 0) busyLeft--;
        else if (charValid) mdlApply(charIn);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycleCheck();
        int fr = 0, fc = 0;
        bit found = 0;
        chk("charReady", int'(charReady), int'(busyLeft == 0));
        chk("busy", int'(busy), int'(busyLeft != 0));
        chk("cursorRow", int'(cursorRow), mRow);
        chk("cursorCol", int'(cursorCol), mCol);
        if (busyLeft == 0) begin
            for (int r = 0; r < 30; r++)
                for (int c = 0; c < 80; c++)
                    if (!found && charBuffer[r][c] !== mdl[r][c]) begin
                        found = 1;
                        fr = r;
                        fc = c;
                    end
            chk($sformatf("cell[%0d][%0d]", fr, fc), int'(charBuffer[fr][fc]), int'(mdl[fr][fc]));
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 0;
        @(posedge clk);
        #2;
        charIn = b;
        charValid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = charReady;
            @(posedge clk);
            #2;
        end
        charValid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (charReady) break;
            n++;
        end
        chk(name, n, 30);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                cycleCheck();
            end
        join_none
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset charReady", int'(charReady), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset cell[5][5]", int'(charBuffer[5][5]), 8'h20);
        // "AB"
        sendStr("AB");
        @(negedge clk);
        chk("AB cell[0][0]", int'(charBuffer[0][0]), 8'h41);
        chk("AB cell[0][1]", int'(charBuffer[0][1]), 8'h42);
        chk("AB cursorCol", int'(cursorCol), 2);
        // full row of X wraps to the next row without scrolling
        send(CH_CR);
        for (int i = 0; i < 80; i++) send(8'h58);
        @(negedge clk);
        chk("row0 all X", int'(charBuffer[0] == {80{8'h58}}), 1);
        chk("wrap cursorRow", int'(cursorRow), 1);
        chk("wrap cursorCol", int'(cursorCol), 0);
        // tagged rows then scroll from (29,5)
        for (int r = 1; r < 29; r++) begin
            send(8'(97 + r % 26));
            send(CH_LF);
        end
        sendStr("abcde");
        send(CH_LF);
        waitIdle("scroll busy cycles");
        chk("scroll cursorRow", int'(cursorRow), 29);
        chk("scroll cursorCol", int'(cursorCol), 0);
        chk("scroll cell[0][0]", int'(charBuffer[0][0]), 8'h62);
        chk("scroll cell[28][4]", int'(charBuffer[28][4]), 8'h65);
        chk("scroll cell[29][0]", int'(charBuffer[29][0]), 8'h20);
        // backspace across a row boundary and at the origin
        send(CH_FF);
        waitIdle("clear busy cycles");
        sendStr("\n\n\n");
        send(CH_BS);
        @(negedge clk);
        chk("bs wrap cursorRow", int'(cursorRow), 2);
        chk("bs wrap cursorCol", int'(cursorCol), 79);
        send(CH_FF);
        waitIdle("clear busy cycles");
        send(CH_BS);
        @(negedge clk);
        chk("bs origin cursorCol", int'(cursorCol), 0);
        sendStr("hi");
        send(CH_BS);
        @(negedge clk);
        chk("bs cell[0][0]", int'(charBuffer[0][0]), 8'h68);
        chk("bs cell[0][1]", int'(charBuffer[0][1]), 8'h20);
        chk("bs cursorCol", int'(cursorCol), 1);
        // tabs, including the one that overflows the row
        send(CH_CR);
        for (int i = 0; i < 9; i++) send(CH_TAB);
        sendStr("xyz");
        send(CH_TAB);
        @(negedge clk);
        chk("tab wrap cursorRow", int'(cursorRow), 1);
        chk("tab wrap cursorCol", int'(cursorCol), 0);
        send(CH_FF);
        waitIdle("clear busy cycles");
        sendStr("abc");
        send(CH_TAB);
        send(8'h01);
        send(8'h7F);
        @(negedge clk);
        chk("tab cursorCol", int'(cursorCol), 8);
        chk("tab cell[0][2]", int'(charBuffer[0][2]), 8'h63);
        send(CH_FF);
        waitIdle("clear busy cycles");
        chk("ff cell[0][0]", int'(charBuffer[0][0]), 8'h20);
        // reset during a scroll while the source keeps offering a byte
        for (int i = 0; i < 29; i++) send(CH_LF);
        send(8'h71);
        send(CH_LF);
        charIn = 8'h5A;
        charValid = 1'b1;
        repeat (9) @(posedge clk);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        charValid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset charReady", int'(charReady), 1);
        chk("post-reset cursorRow", int'(cursorRow), 0);
        chk("post-reset cell[29][0]", int'(charBuffer[29][0]), 8'h20);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
